// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: register file, ALU, PC/branch logic and decode, with a
// stalling load/store handshake toward the data memory.
//   state  | meaning
//   ST_RUN | execute; non-memory instructions retire every cycle
//   ST_MEM | memory request outstanding, held until MEM_BUSY is seen low
module cpu_core_mc #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [7:0]        MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSY
);
    localparam int REG_AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MEM = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] regs [NREGS];

    logic [7:0]        op;
    logic [7:0]        imm_field;
    logic [REG_AW-1:0] dst_idx, src1_idx, src2_idx;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_val, diff, alu_res, addr_opnd;
    logic [7:0]        addr_byte;
    logic [PC_W-1:0]   pc_seq, pc_br;

    logic [REG_AW-1:0] ld_dst, ld_dst_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              mem_rd_nxt, mem_wr_nxt;
    logic [7:0]        addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              unused_bits;

    assign op        = INSTRUCTION[31:24];
    assign imm_field = INSTRUCTION[7:0];
    assign dst_idx   = INSTRUCTION[16 +: REG_AW];
    assign src1_idx  = INSTRUCTION[8 +: REG_AW];
    assign src2_idx  = INSTRUCTION[0 +: REG_AW];

    assign rs1_val = regs[src1_idx];
    assign rs2_val = regs[src2_idx];

    // Subtraction goes through the two's-complement adder; beq reuses it.
    assign diff = rs1_val + (~rs2_val + DATA_W'(1));

    assign addr_opnd = (op == OP_LWD || op == OP_SWD) ? rs2_val : imm_val;

    generate
        if (DATA_W > 8) begin : g_wide
            assign imm_val   = {{(DATA_W-8){1'b0}}, imm_field};
            assign addr_byte = addr_opnd[7:0];
        end else if (DATA_W == 8) begin : g_byte
            assign imm_val   = imm_field;
            assign addr_byte = addr_opnd;
        end else begin : g_narrow
            assign imm_val   = imm_field[DATA_W-1:0];
            assign addr_byte = {{(8-DATA_W){1'b0}}, addr_opnd};
        end
    endgenerate

    assign unused_bits = ^{INSTRUCTION[15:8], imm_field, addr_opnd};

    assign pc_seq = PC + PC_W'(1);
    assign pc_br  = PC + PC_W'(1) + PC_W'($signed(INSTRUCTION[23:16]));

    always_comb begin
        alu_res = '0;
        case (op)
            OP_LOADI: alu_res = imm_val;
            OP_MOV:   alu_res = rs2_val;
            OP_ADD:   alu_res = rs1_val + rs2_val;
            OP_SUB:   alu_res = diff;
            OP_AND:   alu_res = rs1_val & rs2_val;
            OP_OR:    alu_res = rs1_val | rs2_val;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = PC;
        reg_we     = 1'b0;
        reg_waddr  = dst_idx;
        reg_wdata  = alu_res;
        mem_rd_nxt = MEM_READ;
        mem_wr_nxt = MEM_WRITE;
        addr_nxt   = MEM_ADDR;
        wdata_nxt  = MEM_WDATA;
        ld_dst_nxt = ld_dst;

        case (state)
            ST_RUN: begin
                case (op)
                    OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        reg_we = 1'b1;
                        pc_nxt = pc_seq;
                    end
                    OP_J:   pc_nxt = pc_br;
                    OP_BEQ: pc_nxt = (diff == '0) ? pc_br : pc_seq;
                    OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                        mem_rd_nxt = (op == OP_LWD || op == OP_LWI);
                        mem_wr_nxt = (op == OP_SWD || op == OP_SWI);
                        addr_nxt   = addr_byte;
                        wdata_nxt  = rs1_val;
                        ld_dst_nxt = dst_idx;
                        state_nxt  = ST_MEM;
                    end
                    default: pc_nxt = pc_seq;
                endcase
            end
            ST_MEM: begin
                if (!MEM_BUSY) begin
                    if (MEM_READ) begin
                        reg_we    = 1'b1;
                        reg_waddr = ld_dst;
                        reg_wdata = MEM_RDATA;
                    end
                    mem_rd_nxt = 1'b0;
                    mem_wr_nxt = 1'b0;
                    pc_nxt     = pc_seq;
                    state_nxt  = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_RUN;
            PC        <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            ld_dst    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            MEM_READ  <= mem_rd_nxt;
            MEM_WRITE <= mem_wr_nxt;
            MEM_ADDR  <= addr_nxt;
            MEM_WDATA <= wdata_nxt;
            ld_dst    <= ld_dst_nxt;
            if (reg_we) regs[reg_waddr] <= reg_wdata;
        end
    end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Scoreboard bench for cpu_core_mc: an ISA-level model predicts every data-memory
// request and the final PC; a negedge monitor answers requests and checks them.
module tb_cpu_core_mc;
    localparam logic [31:0] SPIN = 32'h06FF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_busy = 1'b0;

    logic [31:0] imem [256];
    logic [7:0]  seed [256];
    logic [7:0]  dmem [256];

    logic        rst16;
    logic [31:0] pc16;
    logic [31:0] instr16;
    logic        mem_read16, mem_write16;
    logic [7:0]  mem_addr16;
    logic [15:0] mem_wdata16;
    logic [31:0] imem16 [16];

    always #5 clk = ~clk;

    assign instr     = imem[pc[7:0]];
    assign mem_rdata = dmem[mem_addr];
    assign instr16   = imem16[pc16[3:0]];

    cpu_core_mc #(.DATA_W(8), .NREGS(8), .PC_W(32)) dut (
        .CLK(clk), .RESET(rst_n), .PC(pc), .INSTRUCTION(instr),
        .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_BUSY(mem_busy)
    );

    cpu_core_mc #(.DATA_W(16), .NREGS(16), .PC_W(32)) dut16 (
        .CLK(clk), .RESET(rst16), .PC(pc16), .INSTRUCTION(instr16),
        .MEM_READ(mem_read16), .MEM_WRITE(mem_write16), .MEM_ADDR(mem_addr16),
        .MEM_WDATA(mem_wdata16), .MEM_RDATA(16'h0000), .MEM_BUSY(1'b0)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] pc;
        int          n;      // busy cycles to insert, -1 = random
    } req_t;

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Monitor + memory responder
    req_t cur;
    bit   cur_ok = 0, prev_act = 0, act;
    int   busy_left = 0, act_cycles = 0, exp_cycles = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_act  = 0;
            busy_left = 0;
            mem_busy  = 1'b0;
            for (int i = 0; i < 256; i++) dmem[i] = seed[i];
        end else begin
            act = mem_read | mem_write;
            if (act) chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (act && !prev_act) begin
                act_cycles = 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: got addr %0h at pc %0h, expected no request", mem_addr, pc);
                    cur_ok = 0;
                    busy_left = 0;
                    exp_cycles = 1;
                end else begin
                    cur = exp_q.pop_front();
                    cur_ok = 1;
                    chk("req_type", {31'b0, mem_write}, {31'b0, cur.wr});
                    chk("req_addr", mem_addr, cur.addr);
                    if (cur.wr) chk("req_wdata", mem_wdata, cur.wdata);
                    chk("req_pc", pc, cur.pc);
                    busy_left  = (cur.n < 0) ? int'($urandom_range(0, 3)) : cur.n;
                    exp_cycles = busy_left + 1;
                end
            end else if (act) begin
                act_cycles++;
                if (cur_ok) begin
                    chk("hold_type", {30'b0, mem_read, mem_write}, cur.wr ? 32'd1 : 32'd2);
                    chk("hold_addr", mem_addr, cur.addr);
                    chk("hold_pc", pc, cur.pc);
                end
            end else if (prev_act) begin
                chk("mem_cycles", act_cycles, exp_cycles);
            end
            if (act && mem_write && busy_left == 0) dmem[mem_addr] = mem_wdata;
            mem_busy = act && (busy_left > 0);
            if (mem_busy) busy_left--;
            prev_act = act;
        end
    end

    // ISA-level reference: walks the program until the j -1 spin and predicts requests.
    task automatic model_run(output int final_pc);
        logic [7:0]  r [8];
        logic [7:0]  m [256];
        logic [31:0] w;
        logic [7:0]  op, imm, addr;
        int          d, a, b, p;
        for (int i = 0; i < 8; i++) r[i] = 8'h00;
        for (int i = 0; i < 256; i++) m[i] = seed[i];
        p = 0;
        for (int step = 0; step < 3000; step++) begin
            w = imem[p[7:0]];
            op = w[31:24]; imm = w[7:0];
            d = int'(w[18:16]); a = int'(w[10:8]); b = int'(w[2:0]);
            if (op == 8'd6 && w[23:16] == 8'hFF) break;
            case (op)
                8'd0: begin r[d] = imm;           p++; end
                8'd1: begin r[d] = r[b];          p++; end
                8'd2: begin r[d] = r[a] + r[b];   p++; end
                8'd3: begin r[d] = r[a] - r[b];   p++; end
                8'd4: begin r[d] = r[a] & r[b];   p++; end
                8'd5: begin r[d] = r[a] | r[b];   p++; end
                8'd6: p = p + 1 + int'($signed(w[23:16]));
                8'd7: p = (r[a] == r[b]) ? p + 1 + int'($signed(w[23:16])) : p + 1;
                8'd8, 8'd9: begin
                    addr = (op == 8'd8) ? r[b] : imm;
                    exp_q.push_back('{1'b0, addr, 8'h00, 32'(p), -1});
                    r[d] = m[addr];
                    p++;
                end
                8'd10, 8'd11: begin
                    addr = (op == 8'd10) ? r[b] : imm;
                    exp_q.push_back('{1'b1, addr, r[a], 32'(p), -1});
                    m[addr] = r[a];
                    p++;
                end
                default: p++;
            endcase
        end
        final_pc = p;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) imem[i] = SPIN;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int final_pc, input string name);
        bit done = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_read && !mem_write) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d requests pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (60) @(negedge clk);
        chk({name, "_final_pc"}, pc, final_pc);
    endtask

    initial begin
        int  fpc;
        bit  seen;
        logic [7:0] op;
        rst_n = 1'b0;
        rst16 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            seed[i] = 8'($urandom);
            imem[i] = SPIN;
        end
        for (int i = 0; i < 16; i++) imem16[i] = SPIN;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_rw", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        // add / sub and one-instruction-per-cycle timing
        hold_reset();
        imem[0] = ins(0, 1, 0, 8'd5);
        imem[1] = ins(0, 2, 0, 8'd3);
        imem[2] = ins(2, 3, 1, 2);
        imem[3] = ins(3, 4, 2, 1);
        imem[4] = ins(11, 0, 3, 8'h01);
        imem[5] = ins(11, 0, 4, 8'h02);
        exp_q.push_back('{1'b1, 8'h01, 8'h08, 32'd4, 0});
        exp_q.push_back('{1'b1, 8'h02, 8'hFE, 32'd5, 0});
        release_reset();
        repeat (4) @(posedge clk);
        #1 chk("t1_pc_after_4", pc, 32'd4);
        wait_done(6, "t1");

        // wrap-around add, and, or
        hold_reset();
        imem[0] = ins(0, 1, 0, 8'hF0);
        imem[1] = ins(0, 2, 0, 8'h20);
        imem[2] = ins(2, 5, 1, 2);
        imem[3] = ins(4, 6, 1, 2);
        imem[4] = ins(5, 7, 1, 2);
        imem[5] = ins(11, 0, 5, 8'h03);
        imem[6] = ins(11, 0, 6, 8'h04);
        imem[7] = ins(11, 0, 7, 8'h05);
        exp_q.push_back('{1'b1, 8'h03, 8'h10, 32'd5, 1});
        exp_q.push_back('{1'b1, 8'h04, 8'h20, 32'd6, 0});
        exp_q.push_back('{1'b1, 8'h05, 8'hF0, 32'd7, 2});
        release_reset();
        wait_done(8, "t2");

        // j backward, beq not taken, beq same register taken; traps catch wrong paths
        hold_reset();
        for (int i = 3; i < 8; i++) imem[i] = ins(11, 0, 0, 8'hEE);
        imem[0]  = ins(0, 1, 0, 8'd1);
        imem[1]  = ins(0, 2, 0, 8'd2);
        imem[2]  = ins(6, 8'd7, 0, 0);
        imem[10] = ins(6, 8'hFD, 0, 0);
        imem[8]  = ins(7, 8'd5, 1, 2);
        imem[9]  = ins(7, 8'd2, 1, 1);
        imem[11] = ins(11, 0, 1, 8'h66);
        imem[12] = ins(11, 0, 2, 8'h07);
        exp_q.push_back('{1'b1, 8'h07, 8'h02, 32'd12, 0});
        release_reset();
        wait_done(13, "t3");

        // stalled store, zero-wait load, store of the loaded value
        hold_reset();
        imem[0] = ins(0, 1, 0, 8'h5A);
        imem[1] = ins(11, 0, 1, 8'h40);
        imem[2] = ins(0, 3, 0, 8'h40);
        imem[3] = ins(8, 2, 0, 3);
        imem[4] = ins(11, 0, 2, 8'h41);
        exp_q.push_back('{1'b1, 8'h40, 8'h5A, 32'd1, 3});
        exp_q.push_back('{1'b0, 8'h40, 8'h00, 32'd3, 0});
        exp_q.push_back('{1'b1, 8'h41, 8'h5A, 32'd4, 1});
        release_reset();
        wait_done(5, "t4");

        // asynchronous reset in the middle of an lwi
        hold_reset();
        seed[8'h10] = 8'hAB;
        imem[0] = ins(9, 1, 0, 8'h10);
        exp_q.push_back('{1'b0, 8'h10, 8'h00, 32'd0, 50});
        release_reset();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_read) begin seen = 1; break; end
        end
        chk("t5_read_seen", {31'b0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_read", {31'b0, mem_read}, 32'd0);
        chk("t5_async_pc", pc, 32'd0);
        chk("t5_async_addr", mem_addr, 32'd0);
        exp_q.delete();
        imem[0] = ins(11, 0, 1, 8'h20);
        exp_q.push_back('{1'b1, 8'h20, 8'h00, 32'd0, 0});
        release_reset();
        wait_done(1, "t5");

        // randomized programs against the model
        for (int t = 0; t < 8; t++) begin
            hold_reset();
            for (int i = 0; i < 256; i++) seed[i] = 8'($urandom);
            for (int i = 0; i < 40; i++) begin
                op = 8'($urandom_range(0, 13));
                if (op == 8'd13) op = 8'hFF;
                if (op == 8'd6 || op == 8'd7)
                    imem[i] = ins(op, 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                else
                    imem[i] = ins(op, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            model_run(fpc);
            release_reset();
            wait_done(fpc, "rand");
        end

        // 16-bit data, 16 registers, unknown opcode as NOP
        imem16[0] = ins(0, 8'd15, 0, 8'hFF);
        imem16[1] = ins(2, 8'd15, 8'd15, 8'd15);
        imem16[2] = ins(8'hFF, 8'd3, 8'd3, 8'd3);
        imem16[3] = ins(11, 0, 8'd15, 8'h00);
        @(negedge clk);
        #1 rst16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("w16_pc_after_nop", pc16, 32'd3);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_write16) begin seen = 1; break; end
        end
        chk("w16_write_seen", {31'b0, seen}, 32'd1);
        chk("w16_wdata", {16'b0, mem_wdata16}, 32'h01FE);
        chk("w16_addr", mem_addr16, 32'd0);
        repeat (4) @(negedge clk);
        chk("w16_final_pc", pc16, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
